// File: rtl/pipe_skid_stage.sv
// Elastic valid/ready pipeline register with a 2-entry skid buffer; in_ready comes from registered state only.
// Optional stall counter output enabled by defining PIPE_SKID_STALL_CNT_EN.
module pipe_skid_stage #(
    parameter int unsigned DATA_W         = 32,
    parameter bit          CLEAR_ON_FLUSH = 1'b1,
    parameter int unsigned CNT_W          = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
`ifdef PIPE_SKID_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cycles
`endif
);

    // Encoding chosen so bit 0 is main_v and bit 1 is skid_v.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] main_d;
    logic [DATA_W-1:0] skid_d;
    logic              main_v;
    logic              skid_v;
    logic              acc;
    logic              drn;

    assign main_v    = state[0];
    assign skid_v    = state[1];
    assign in_ready  = rst & ~skid_v;
    assign out_valid = main_v;
    assign out_data  = main_d;
    assign occupancy = {1'b0, main_v} + {1'b0, skid_v};
    assign acc       = in_valid & in_ready;
    assign drn       = main_v & out_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= EMPTY;
            main_d <= '0;
            skid_d <= '0;
        end else if (flush) begin
            state <= EMPTY;
            if (CLEAR_ON_FLUSH) begin
                main_d <= '0;
                skid_d <= '0;
            end
        end else begin
            case (state)
                EMPTY: begin
                    if (acc) begin
                        state  <= ONE;
                        main_d <= in_data;
                    end
                end
                ONE: begin
                    if (acc && drn) begin
                        main_d <= in_data;
                    end else if (acc) begin
                        state  <= FULL;
                        skid_d <= in_data;
                    end else if (drn) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (drn) begin
                        state  <= ONE;
                        main_d <= skid_d;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

`ifdef PIPE_SKID_STALL_CNT_EN
    // Saturating; only reset clears it so stalls across a redirect stay visible.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cycles <= '0;
        end else if (out_valid && !out_ready && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Randomized bench for pipe_skid_stage: two instances (8-bit clearing, 96-bit non-clearing) against a queue model.
module tb_pipe_skid_stage;

    localparam int unsigned CW = 4;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [7:0]  in_data8, out_data8;
    logic [95:0] in_data96, out_data96;
    logic        in_ready8, in_ready96, out_valid8, out_valid96;
    logic [1:0]  occ8, occ96;
`ifdef PIPE_SKID_STALL_CNT_EN
    logic [CW-1:0] stall8;
    logic [15:0]   stall96;
`endif

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [95:0] q[$];
    logic [95:0] hold96;
    logic [7:0]  hold8;
    int unsigned scnt8, scnt96;

    always #5 clk = ~clk;

    pipe_skid_stage #(.DATA_W(8), .CLEAR_ON_FLUSH(1'b1), .CNT_W(CW)) u_dut8 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready8), .in_data(in_data8),
        .out_valid(out_valid8), .out_ready(out_ready), .out_data(out_data8),
        .occupancy(occ8)
`ifdef PIPE_SKID_STALL_CNT_EN
        , .stall_cycles(stall8)
`endif
    );

    pipe_skid_stage #(.DATA_W(96), .CLEAR_ON_FLUSH(1'b0), .CNT_W(16)) u_dut96 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready96), .in_data(in_data96),
        .out_valid(out_valid96), .out_ready(out_ready), .out_data(out_data96),
        .occupancy(occ96)
`ifdef PIPE_SKID_STALL_CNT_EN
        , .stall_cycles(stall96)
`endif
    );

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        automatic int unsigned sz = q.size();
        automatic logic        exp_rdy = rst && (sz < 2);
        check("out_valid8", out_valid8, sz > 0);
        check("out_valid96", out_valid96, sz > 0);
        check("occ8", occ8, sz);
        check("occ96", occ96, sz);
        check("in_ready8", in_ready8, exp_rdy);
        check("in_ready96", in_ready96, exp_rdy);
        check("out_data8", out_data8, (sz > 0) ? q[0][7:0] : hold8);
        check("out_data96", out_data96, (sz > 0) ? q[0] : hold96);
`ifdef PIPE_SKID_STALL_CNT_EN
        check("stall8", stall8, scnt8);
        check("stall96", stall96, scnt96);
`endif
    endtask

    task automatic model_update(input logic r, input logic f, input logic iv,
                                input logic [95:0] d, input logic ordy);
        automatic int unsigned sz  = q.size();
        automatic logic        acc = r && iv && (sz < 2);
        automatic logic        drn = (sz > 0) && ordy;
        automatic logic [95:0] last;
        if (!r) begin
            scnt8  = 0;
            scnt96 = 0;
        end else if (sz > 0 && !ordy) begin
            if (scnt8 < (1 << CW) - 1) scnt8++;
            if (scnt96 < 65535) scnt96++;
        end
        if (!r) begin
            q.delete();
            hold8  = '0;
            hold96 = '0;
        end else if (f) begin
            if (sz > 0) hold96 = q[0];
            hold8 = '0;
            q.delete();
        end else begin
            if (drn) begin
                last   = q.pop_front();
                hold96 = last;
                hold8  = last[7:0];
            end
            if (acc) q.push_back(d);
        end
    endtask

    // Called at posedge+1; returns at the following posedge+1.
    task automatic step(input logic r, input logic f, input logic iv,
                        input logic [95:0] d, input logic ordy);
        automatic logic exp_rdy;
        rst = r; flush = f; in_valid = iv; out_ready = ordy;
        in_data96 = d;
        in_data8  = d[7:0];
        #1;
        check_outputs();
        exp_rdy   = r && (q.size() < 2);
        out_ready = ~ordy;
        #1;
        check("in_ready_comb", in_ready8, exp_rdy);
        out_ready = ordy;
        @(posedge clk);
        model_update(r, f, iv, d, ordy);
        #1;
    endtask

    function automatic logic [95:0] rnd96();
        return {$urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        automatic int unsigned bias;
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data8 = '0; in_data96 = '0;
        hold8 = '0; hold96 = '0; scnt8 = 0; scnt96 = 0;
        @(posedge clk);
        #1;

        // Reset held for two cycles
        step(1'b0, 1'b0, 1'b1, 96'h77, 1'b1);
        step(1'b0, 1'b0, 1'b1, 96'h78, 1'b1);
        check("rst_out_valid", out_valid8, 1'b0);
        check("rst_out_data", out_data8, 8'h00);
        check("rst_in_ready", in_ready8, 1'b0);

        // Streaming at full rate with 1-cycle latency
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 1'b0, 1'b1, 96'(i), 1'b1);
            check("stream_data", out_data8, 8'(i));
            check("stream_ready", in_ready8, 1'b1);
        end
        step(1'b1, 1'b0, 1'b0, 96'h0, 1'b1);

        // Backpressure fill then drain
        step(1'b1, 1'b0, 1'b1, 96'hA, 1'b0);
        step(1'b1, 1'b0, 1'b1, 96'hB, 1'b0);
        check("bp_occ", occ8, 2'd2);
        check("bp_ready", in_ready8, 1'b0);
        check("bp_head", out_data8, 8'hA);
        step(1'b1, 1'b0, 1'b1, 96'hEE, 1'b0);
        check("bp_hold", out_data8, 8'hA);
        step(1'b1, 1'b0, 1'b0, 96'h0, 1'b1);
        check("bp_second", out_data8, 8'hB);
        step(1'b1, 1'b0, 1'b0, 96'h0, 1'b1);
        check("bp_empty", out_valid8, 1'b0);

        // Flush while FULL with a simultaneous accept
        step(1'b1, 1'b0, 1'b1, 96'h55, 1'b0);
        step(1'b1, 1'b0, 1'b1, 96'h66, 1'b0);
        step(1'b1, 1'b1, 1'b1, 96'hC, 1'b0);
        check("fl_occ", occ8, 2'd0);
        check("fl_valid", out_valid8, 1'b0);
        check("fl_data_clear", out_data8, 8'h00);
        check("fl_data_keep", out_data96, 96'h55);
        check("fl_ready", in_ready8, 1'b1);
        step(1'b1, 1'b0, 1'b0, 96'h0, 1'b1);
        check("fl_no_c", out_valid8, 1'b0);

`ifdef PIPE_SKID_STALL_CNT_EN
        step(1'b1, 1'b0, 1'b1, 96'h3, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, 96'h0, 1'b0);
        check("stall_sat", stall8, 4'd15);
        step(1'b0, 1'b0, 1'b0, 96'h0, 1'b0);
        check("stall_rst", stall8, 4'd0);
`endif

        // Randomized traffic with varying ready bias, sporadic flush and reset
        bias = 50;
        for (int i = 0; i < 10000; i++) begin
            if (i % 500 == 0) bias = $urandom_range(10, 95);
            step(($urandom_range(0, 299) != 0),
                 ($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 99) < 70),
                 rnd96(),
                 ($urandom_range(0, 99) < bias));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
